// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Loads hit in one cycle or refill a whole line beat by beat; every store goes to memory.
module dcache_ctrl #(
    parameter int ADDR_W      = 30,
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_W       = ADDR_W - INDEX_BITS - OFFSET_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dc_read_req,
    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [3:0]        dc_byte_w_en,
    input  logic [31:0]       dc_wdata,
    output logic [31:0]       dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [LINES-1:0]       valid_r;
    logic [TAG_W-1:0]       tag_mem_r [LINES];
    logic [31:0]            data_mem_r [LINES][WORDS];

    logic [TAG_W-1:0]       lat_tag_r;
    logic [INDEX_BITS-1:0]  lat_idx_r;
    logic [OFFSET_BITS-1:0] lat_off_r;
    logic [OFFSET_BITS-1:0] beat_cnt_r;

    logic [31:0]            dc_rdata_r;
    logic                   dc_rvalid_r;
    logic                   mem_req_r;
    logic                   mem_we_r;
    logic [ADDR_W-1:0]      mem_addr_r;
    logic [31:0]            mem_wdata_r;
    logic [3:0]             mem_wstrb_r;

    logic [TAG_W-1:0]       req_tag_s;
    logic [INDEX_BITS-1:0]  req_idx_s;
    logic [OFFSET_BITS-1:0] req_off_s;
    logic                   hit_s;
    logic                   last_beat_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    assign req_off_s   = dc_addr[OFFSET_BITS-1:0];
    assign req_idx_s   = dc_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_tag_s   = dc_addr[ADDR_W-1 -: TAG_W];
    assign hit_s       = valid_r[req_idx_s] && (tag_mem_r[req_idx_s] == req_tag_s);
    assign last_beat_s = (beat_cnt_r == {OFFSET_BITS{1'b1}});

    assign dc_stall  = (state_r != ST_IDLE);
    assign dc_rdata  = dc_rdata_r;
    assign dc_rvalid = dc_rvalid_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a write takes priority over a simultaneous read.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dc_write_req) begin
                    state_nxt_s = ST_WRITE;
                end else if (dc_read_req && !hit_s) begin
                    state_nxt_s = ST_REFILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (mem_ready && last_beat_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REFILL;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control registers, valid bits and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r     <= '0;
            lat_tag_r   <= '0;
            lat_idx_r   <= '0;
            lat_off_r   <= '0;
            beat_cnt_r  <= '0;
            dc_rdata_r  <= 32'h0000_0000;
            dc_rvalid_r <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'b0000;
        end else begin
            dc_rvalid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (dc_write_req) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= dc_addr;
                        mem_wdata_r <= dc_wdata;
                        mem_wstrb_r <= dc_byte_w_en;
                    end else if (dc_read_req) begin
                        if (hit_s) begin
                            dc_rdata_r  <= data_mem_r[req_idx_s][req_off_s];
                            dc_rvalid_r <= 1'b1;
                        end else begin
                            lat_tag_r   <= req_tag_s;
                            lat_idx_r   <= req_idx_s;
                            lat_off_r   <= req_off_s;
                            beat_cnt_r  <= '0;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= {req_tag_s, req_idx_s, {OFFSET_BITS{1'b0}}};
                            mem_wstrb_r <= 4'b0000;
                        end
                    end
                end
                ST_REFILL: begin
                    if (mem_ready) begin
                        beat_cnt_r <= beat_cnt_r + OFFSET_BITS'(1);
                        if (last_beat_s) begin
                            valid_r[lat_idx_r] <= 1'b1;
                            // The requested word may be arriving on this very beat.
                            dc_rdata_r  <= (lat_off_r == beat_cnt_r) ? mem_rdata
                                                                     : data_mem_r[lat_idx_r][lat_off_r];
                            dc_rvalid_r <= 1'b1;
                            mem_req_r   <= 1'b0;
                        end else begin
                            mem_addr_r <= {lat_tag_r, lat_idx_r, beat_cnt_r + OFFSET_BITS'(1)};
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; a line only becomes visible through its valid bit.
    always_ff @(posedge clk) begin
        if (state_r == ST_REFILL && mem_ready) begin
            data_mem_r[lat_idx_r][beat_cnt_r] <= mem_rdata;
            if (last_beat_s) begin
                tag_mem_r[lat_idx_r] <= lat_tag_r;
            end
        end else if (state_r == ST_IDLE && dc_write_req && hit_s) begin
            data_mem_r[req_idx_s][req_off_s] <= merge_bytes(data_mem_r[req_idx_s][req_off_s],
                                                            dc_wdata, dc_byte_w_en);
        end
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache controller.
- Sits directly downstream of the load/store queue. It consumes the LSQ's dc_read_req/dc_write_req/dc_addr/dc_byte_w_en/dc_wdata and returns dc_rdata.
- dc_stall drives the back-end freeze. Misses and all writes go to a word-wide memory port with a req/ready handshake.

Parameters:
ADDR_W, 30, word-address width (byte address bits [31:2])
INDEX_BITS, 4, line index width (16 lines)
OFFSET_BITS, 2, word-in-line width (4 words/line)
TAG_W, ADDR_W-INDEX_BITS-OFFSET_BITS (24), tag width, derived

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
dc_read_req  in  1  load request, sampled on clk
dc_write_req  in  1  store request, sampled on clk
dc_addr  in  ADDR_W  word address
dc_byte_w_en  in  4  store byte strobes
dc_wdata  in  32  store data
dc_rdata  out  32  load data, registered
dc_rvalid  out  1  one-cycle pulse, dc_rdata valid
dc_stall  out  1  controller busy, no request accepted
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read beat
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte strobes
mem_ready  in  1  beat complete; mem_rdata valid on read
mem_rdata  in  32  memory read data

Behaviour:
- Address split:
  - offset = addr[OFFSET_BITS-1:0]
  - index = next INDEX_BITS
  - tag = remaining upper bits
- Storage:
  - valid bit per line, reset to 0
  - tag array and data array (2^INDEX_BITS x 2^OFFSET_BITS words), not reset
- Reset (rst low, async):
  - All valid bits cleared; state=IDLE; beat_cnt=0.
  - dc_rdata=0, dc_rvalid=0, dc_stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - Reset mid-refill or mid-write aborts the transaction; the partial line is discarded.
- dc_stall = (state != IDLE), combinational from state.
- A request is accepted only in IDLE.
- If dc_read_req and dc_write_req are both high, the write wins and the read is dropped. The LSQ never does this.
- dc_rvalid defaults to 0 every cycle unless set below.
- IDLE, read accepted:
  - Hit (valid[index] && tag match): next cycle dc_rdata = data[index][offset], dc_rvalid=1; stay IDLE. Zero memory traffic.
  - Miss: latch tag/index/offset; beat_cnt=0; go REFILL. dc_stall is high from the next cycle.
- IDLE, write accepted:
  - Latch addr/data/strobes; go WRITE.
  - On hit, merge the strobed bytes into the data array in the same edge.
  - On miss, do not allocate (tag and valid unchanged).
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={tag,index,beat_cnt}, strobes 0. Beats run in order 0..2^OFFSET_BITS-1.
  - mem_addr and mem_req are held stable until mem_ready.
  - On mem_ready: write mem_rdata into data[index][beat_cnt]; beat_cnt++.
  - On the last beat, also:
    - set tag[index] and valid[index]=1;
    - load dc_rdata with the requested word (the mem_rdata of that beat if offset is last);
    - set dc_rvalid=1 for the next cycle;
    - go IDLE (mem_req low next cycle).
  - Load latency: 1 cycle on hit; on miss, 1 + sum of beat latencies.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=latched addr, mem_wdata/mem_wstrb=latched, held stable.
  - On mem_ready go IDLE. No dc_rvalid.
- Back-to-back: a request in the first IDLE cycle after REFILL/WRITE completes is accepted normally. In that same cycle, dc_rvalid from the finished refill is still presented.
- Strobe merge per byte: byte k of the line word is replaced iff dc_byte_w_en[k].
- Index wrap: the index is a pure bit slice; lines 0 and 2^INDEX_BITS-1 behave identically. A conflict miss silently overwrites the line (write-through, nothing dirty).

Test Plan:
- Reset, read 0x010 (index 4, tag 0, off 0); mem returns 0xA0,0xA1,0xA2,0xA3 with mem_ready=1 each cycle -> the following hold:
  - dc_stall is high for 4 cycles;
  - mem_addr steps 0x010..0x013;
  - then dc_rvalid=1, dc_rdata=0xA0.
- Then read 0x012, then 0x011 back-to-back -> each hits; dc_rvalid on the following cycle with 0xA2 then 0xA1; mem_req never asserted.
- Write 0x011, strb 4'b0011, data 0xFFFF1234 -> the following hold:
  - dc_stall high until mem_ready;
  - one mem write: addr 0x011, wdata 0xFFFF1234, wstrb 0011;
  - a subsequent read 0x011 hits, returning 0x00001234.
- Write miss 0x050 (index 4, tag 1), then read 0x010 -> the following hold:
  - no refill for the write;
  - the read 0x010 still hits.
- Then read 0x050 -> refills index 4 with tag 1; a later read 0x010 misses and refills again.
- During a REFILL, hold mem_ready low 3 cycles per beat -> mem_req/mem_addr stay stable, dc_stall stays high, and exactly 4 beats are consumed. Then assert rst low after beat 2 -> the following hold:
  - mem_req=0 and dc_stall=0 immediately;
  - after release, read 0x012 misses again.
